parallel_bus_capture: RTL
=========================

// Module: parallel_bus_capture
// PURPOSE
//  Clock-synchronous successor to the 8-bit parallel viewer. It samples an external parallel bus
//  (data, control lines, WR/RD strobes) through synchronisers and detects strobe rising edges.
//  Each qualifying transaction is stored with a tag in a DEPTH-entry FIFO for readout.
//  The most recent transaction stays in a hold register that drives the seven-segment display.
// PARAMETERS
//  DATA_WIDTH   8   bus data width
//  CTRL_WIDTH   3   sideband control lines captured with data (e.g. reset, dc, cs)
//  DEPTH        16  FIFO entries; power of two, >=2
//  SYNC_STAGES  2   synchroniser flops on every bus input, >=2
// PORTS
//  clk           in   1                      system clock; all logic on posedge
//  nreset        in   1                      asynchronous active-low reset
//  bus_data      in   DATA_WIDTH             external data bus (asynchronous)
//  bus_ctrl      in   CTRL_WIDTH             external control lines (asynchronous)
//  bus_wr        in   1                      write strobe (asynchronous)
//  bus_rd        in   1                      read strobe (asynchronous)
//  bus_cs_n      in   1                      chip select, active low (asynchronous)
//  capture_mode  in   2                      0 WR edges, 1 RD edges, 2 both, 3 capture off
//  clear         in   1                      sync: empty FIFO, clear sticky flags
//  pop           in   1                      sync: dequeue one entry when !empty
//  entry         out  1+CTRL_WIDTH+DATA_WIDTH {is_rd, ctrl, data} at FIFO head; valid when !empty
//  empty         out  1                      FIFO empty
//  full          out  1                      FIFO holds DEPTH entries
//  count         out  $clog2(DEPTH)+1        entries held, 0..DEPTH
//  overflow      out  1                      sticky: a capture was dropped because FIFO full
//  collision     out  1                      sticky: WR and RD edges seen in same cycle (mode 2)
//  last_data     out  DATA_WIDTH             data of most recent accepted capture (display)
//  last_ctrl     out  CTRL_WIDTH             ctrl of most recent accepted capture
// BEHAVIOUR
//  Reset (nreset=0, async): all sync flops 0; FIFO pointers 0; empty=1, full=0, count=0,
//   overflow=0, collision=0; last_data=0, last_ctrl=0; entry=0.
//  Sync: bus_data, bus_ctrl, bus_wr, bus_rd, bus_cs_n each pass through SYNC_STAGES flops,
//   so data and strobe stay aligned. Edge = sync strobe 1 with previous-stage copy 0.
//  Data must be stable >= SYNC_STAGES+1 clk around each strobe rising edge; not checked.
//  Event: wr_edge when mode is 0 or 2; rd_edge when mode is 1 or 2; none in mode 3.
//   A capture is the synced {is_rd, ctrl, data} at the edge cycle.
//  Latency: bus strobe rise -> entry in FIFO/last_* updated after SYNC_STAGES+2 clk (max).
//  Simultaneous WR and RD edges (mode 2): WR captured (is_rd=0), RD discarded, collision<=1.
//  FIFO push: if !full -> write at wptr, count+1, last_* updated.
//   If full and pop in same cycle -> pop then push both occur, count unchanged, no overflow.
//   If full and no pop -> capture dropped, overflow<=1, last_* still updated.
//  FIFO pop: pop && !empty -> rptr+1, count-1; pop while empty is ignored.
//   entry shows the new head on the next clk (registered, first-word-fall-through).
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full = count==DEPTH; empty = count==0.
//  clear: pointers/count 0, overflow=0, collision=0 next clk. last_* are kept.
//   clear overrides pop and any same-cycle capture, which is discarded.
//  capture_mode changes take effect on the next clk. An edge already in the sync chain is
//   judged by the mode at its edge cycle.
//  Async reset mid-capture: entry lost, all state at reset values, no partial write.
// CONFIGURATION
//  CAPTURE_CS_FILTER_EN defined: an event is accepted only if synced bus_cs_n==0 in the edge
//   cycle. Otherwise it is ignored: no push, no flag change, last_* unchanged.
//  Not defined: bus_cs_n is ignored for qualification and all edges per capture_mode are
//   captured. bus_cs_n is still synchronised but unused.
// TESTING
//  1 mode=0, data=8'hA5, ctrl=3'b101, one WR pulse -> after <=4 clk: count=1, entry={0,101,A5},
//    last_data=A5.
//  2 mode=2, 16 WR pulses (data 0..15), then a 17th (data 8'h10) -> full=1, overflow=1,
//    last_data=10. Pop x16 yields 00..0F in order, then empty=1.
//  3 full FIFO with WR edge and pop in same cycle -> count stays 16, overflow stays 0,
//    tail entry = new data.
//  4 mode=2, WR and RD rise together (data 8'h3C) -> one entry, is_rd=0, collision=1;
//    clear -> collision=0, empty=1.
//  5 mode=3, 5 WR/RD pulses -> count=0, last_data unchanged. mode=1, one RD pulse ->
//    entry is_rd=1.
//  6 CAPTURE_CS_FILTER_EN: WR pulse with bus_cs_n=1 -> count=0. With bus_cs_n=0 -> count=1.
//    Assert nreset mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/parallel_bus_capture.sv
// parallel_bus_capture
//   Samples an asynchronous parallel bus through synchroniser chains, detects WR/RD strobe
//   rising edges and queues each accepted transaction as {is_rd, ctrl, data} in a FIFO.
//   The most recent accepted transaction is held in last_data/last_ctrl for the display.
//   Optional feature macro: CAPTURE_CS_FILTER_EN (accept events only while synced bus_cs_n==0).
module parallel_bus_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int CTRL_WIDTH  = 3,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic [DATA_WIDTH-1:0]            bus_data,
  input  logic [CTRL_WIDTH-1:0]            bus_ctrl,
  input  logic                             bus_wr,
  input  logic                             bus_rd,
  input  logic                             bus_cs_n,
  input  logic [1:0]                       capture_mode,
  input  logic                             clear,
  input  logic                             pop,
  output logic [CTRL_WIDTH+DATA_WIDTH:0]   entry,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             overflow,
  output logic                             collision,
  output logic [DATA_WIDTH-1:0]            last_data,
  output logic [CTRL_WIDTH-1:0]            last_ctrl
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = DATA_WIDTH + CTRL_WIDTH + 3;
  localparam int EW = 1 + CTRL_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // All bus inputs travel together through one chain so data and strobes stay aligned.
  logic [IW-1:0] w_busIn;
  logic [IW-1:0] r_sync [SYNC_STAGES];
  logic          r_wrPrev;
  logic          r_rdPrev;

  logic [DATA_WIDTH-1:0] w_syncData;
  logic [CTRL_WIDTH-1:0] w_syncCtrl;
  logic                  w_syncWr;
  logic                  w_syncRd;
  logic                  w_syncCsN;

  logic w_wrEvent;
  logic w_rdEvent;
  logic w_csOk;
  logic w_capture;
  logic w_bothEvents;
  logic [EW-1:0] w_pushData;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_collision;
  logic [DATA_WIDTH-1:0] r_lastData;
  logic [CTRL_WIDTH-1:0] r_lastCtrl;
  logic [EW-1:0] r_entry;

  logic          w_full;
  logic          w_doPop;
  logic          w_doPush;
  logic          w_drop;
  logic [PW-1:0] w_nextRptr;
  logic [CW-1:0] w_nextCount;
  logic [EW-1:0] w_nextHead;

  assign w_busIn = {bus_cs_n, bus_rd, bus_wr, bus_ctrl, bus_data};

  // Synchroniser chains plus one delayed strobe copy used for rising-edge detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_wrPrev <= 1'b0;
      r_rdPrev <= 1'b0;
    end else begin
      r_sync[0] <= w_busIn;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_wrPrev <= w_syncWr;
      r_rdPrev <= w_syncRd;
    end
  end

  assign w_syncData = r_sync[SYNC_STAGES-1][DATA_WIDTH-1:0];
  assign w_syncCtrl = r_sync[SYNC_STAGES-1][DATA_WIDTH +: CTRL_WIDTH];
  assign w_syncWr   = r_sync[SYNC_STAGES-1][DATA_WIDTH+CTRL_WIDTH];
  assign w_syncRd   = r_sync[SYNC_STAGES-1][DATA_WIDTH+CTRL_WIDTH+1];
  assign w_syncCsN  = r_sync[SYNC_STAGES-1][DATA_WIDTH+CTRL_WIDTH+2];

`ifdef CAPTURE_CS_FILTER_EN
  assign w_csOk = ~w_syncCsN;
`else
  logic w_unusedCsN;
  assign w_unusedCsN = w_syncCsN;
  assign w_csOk      = 1'b1;
`endif

  // The mode is judged in the edge cycle itself; WR wins when both strobes rise together.
  assign w_wrEvent    = w_syncWr & ~r_wrPrev & ((capture_mode == 2'd0) | (capture_mode == 2'd2));
  assign w_rdEvent    = w_syncRd & ~r_rdPrev & ((capture_mode == 2'd1) | (capture_mode == 2'd2));
  assign w_capture    = (w_wrEvent | w_rdEvent) & w_csOk;
  assign w_bothEvents = w_wrEvent & w_rdEvent & w_csOk;
  assign w_pushData   = {~w_wrEvent, w_syncCtrl, w_syncData};

  assign w_full     = (r_count == FULL_COUNT);
  assign w_doPop    = pop & (r_count != '0) & ~clear;
  assign w_doPush   = w_capture & (~w_full | w_doPop) & ~clear;
  assign w_drop     = w_capture & w_full & ~w_doPop;
  assign w_nextRptr = r_rptr + PW'(w_doPop);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_nextCount = r_count;
    if (w_doPush && !w_doPop) begin
      w_nextCount = r_count + CW'(1);
    end else if (!w_doPush && w_doPop) begin
      w_nextCount = r_count - CW'(1);
    end
  end

  // Next head word, bypassing the memory when the word being pushed becomes the head.
  always_comb begin
    w_nextHead = r_entry;
    if (w_nextCount != '0) begin
      if (w_doPush && (r_wptr == w_nextRptr)) begin
        w_nextHead = w_pushData;
      end else begin
        w_nextHead = r_mem[w_nextRptr];
      end
    end
  end

  // Storage array; written only for accepted pushes, so a reset never leaves a partial entry.
  always_ff @(posedge clk) begin
    if (nreset && w_doPush) begin
      r_mem[r_wptr] <= w_pushData;
    end
  end

  // Pointers, occupancy, sticky flags, display hold register and registered head word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
      r_lastData  <= '0;
      r_lastCtrl  <= '0;
      r_entry     <= '0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + PW'(1);
      r_rptr  <= w_nextRptr;
      r_count <= w_nextCount;
      r_entry <= w_nextHead;
      if (w_capture) begin
        r_lastData <= w_syncData;
        r_lastCtrl <= w_syncCtrl;
      end
      if (w_drop)       r_overflow  <= 1'b1;
      if (w_bothEvents) r_collision <= 1'b1;
    end
  end

  assign entry     = r_entry;
  assign empty     = (r_count == '0);
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign collision = r_collision;
  assign last_data = r_lastData;
  assign last_ctrl = r_lastCtrl;

endmodule
